// File: rtl/ocp_slave_mem_pkg.sv
// Shared OCP encodings for the single-outstanding-transaction memory slave:
// command, response and burst codes plus the slave FSM state type.
package ocp_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE = 3'b000,
        CMD_WR   = 3'b001,
        CMD_RD   = 3'b010
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NULL = 2'b00,
        RESP_DVA  = 2'b01,
        RESP_ERR  = 2'b11
    } resp_e;

    typedef enum logic [2:0] {
        BSEQ_INCR = 3'b000
    } bseq_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDRESP
    } state_e;

endpackage

// File: rtl/ocp_slave_mem_if.sv
// OCP request/data/response bundle between a master and the memory slave.
interface ocp_slave_mem_if #(
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4,
    parameter int BLEN_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0]   m_addr;
    logic [BLEN_WIDTH-1:0]   m_burst_length;
    logic [2:0]              m_burst_seq;
    logic [DATA_WIDTH/8-1:0] m_byteen;
    logic [2:0]              m_cmd;
    logic [DATA_WIDTH-1:0]   m_data;
    logic [DATA_WIDTH/8-1:0] m_data_byteen;
    logic                    m_data_last;
    logic [TAGI_WIDTH-1:0]   m_data_tagid;
    logic                    m_data_valid;
    logic [INFO_WIDTH-1:0]   m_req_info;
    logic                    m_resp_accept;
    logic [TAGI_WIDTH-1:0]   m_tagid;
    logic                    s_cmd_accept;
    logic [DATA_WIDTH-1:0]   s_data;
    logic                    s_data_accept;
    logic [1:0]              s_resp;
    logic                    s_resp_last;
    logic [TAGI_WIDTH-1:0]   s_tagid;

    modport slave (
        input  m_addr, m_burst_length, m_burst_seq, m_byteen, m_cmd, m_data,
               m_data_byteen, m_data_last, m_data_tagid, m_data_valid,
               m_req_info, m_resp_accept, m_tagid,
        output s_cmd_accept, s_data, s_data_accept, s_resp, s_resp_last, s_tagid
    );

    modport master (
        output m_addr, m_burst_length, m_burst_seq, m_byteen, m_cmd, m_data,
               m_data_byteen, m_data_last, m_data_tagid, m_data_valid,
               m_req_info, m_resp_accept, m_tagid,
        input  s_cmd_accept, s_data, s_data_accept, s_resp, s_resp_last, s_tagid
    );

endinterface

// File: rtl/ocp_slave_mem_array.sv
// Word-addressed storage with a byte-enabled synchronous write port and an
// asynchronous read port. Deliberately has no reset so contents survive rst.
module ocp_mem_array #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wbe,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (i_wbe[b]) begin
                    r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ocp_slave_mem.sv
// OCP burst memory slave: one transaction in flight, INCR bursts wrap modulo
// the memory depth, responses are registered and held until accepted.
module ocp_slave_mem
    import ocp_pkg::*;
#(
    parameter int TAGI_WIDTH = 5,
    parameter int INFO_WIDTH = 4,
    parameter int BLEN_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic            clk,
    input logic            rst,
    ocp_slave_mem_if.slave bus
);

    localparam logic [BLEN_WIDTH-1:0] BLEN_ONE = BLEN_WIDTH'(1);

    state_e                  r_state, w_nextState;
    logic [ADDR_WIDTH-1:0]   r_addr, w_nextAddr;
    logic [BLEN_WIDTH-1:0]   r_lastIdx, w_nextLastIdx;
    logic [BLEN_WIDTH-1:0]   r_beat, w_nextBeat;
    logic [TAGI_WIDTH-1:0]   r_tag, w_nextTag;
    logic [2:0]              r_bseq, w_nextBseq;
    logic [1:0]              r_resp, w_nextResp;
    logic                    r_respLast, w_nextRespLast;
    logic [DATA_WIDTH-1:0]   r_data, w_nextData;
    logic [TAGI_WIDTH-1:0]   r_tagid, w_nextTagid;
    logic                    w_memWe;
    logic [ADDR_WIDTH-1:0]   w_memWaddr;
    logic [ADDR_WIDTH-1:0]   w_memRaddr;
    logic [DATA_WIDTH-1:0]   w_memRdata;
    logic                    w_bseqOk;
    logic                    w_unusedInputs;

    assign w_unusedInputs = ^{bus.m_byteen, bus.m_req_info};
    assign w_bseqOk       = (r_bseq == BSEQ_INCR);
    assign w_memWaddr     = r_addr + ADDR_WIDTH'(r_beat);

    // Read port looks ahead: the first beat of a read is loaded from the
    // incoming address, later beats from the word after the one on the bus.
    always_comb begin
        w_memRaddr = r_addr + ADDR_WIDTH'(r_beat + BLEN_ONE);
        if (r_state == ST_IDLE) begin
            w_memRaddr = bus.m_addr;
        end
    end

    ocp_mem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_memWe),
        .i_waddr (w_memWaddr),
        .i_wdata (bus.m_data),
        .i_wbe   (bus.m_data_byteen),
        .i_raddr (w_memRaddr),
        .o_rdata (w_memRdata)
    );

    always_comb begin
        w_nextState    = r_state;
        w_nextAddr     = r_addr;
        w_nextLastIdx  = r_lastIdx;
        w_nextBeat     = r_beat;
        w_nextTag      = r_tag;
        w_nextBseq     = r_bseq;
        w_nextResp     = r_resp;
        w_nextRespLast = r_respLast;
        w_nextData     = r_data;
        w_nextTagid    = r_tagid;
        w_memWe        = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (bus.m_cmd != CMD_IDLE) begin
                    w_nextAddr    = bus.m_addr;
                    w_nextLastIdx = (bus.m_burst_length == '0) ? '0
                                    : bus.m_burst_length - BLEN_ONE;
                    w_nextBeat    = '0;
                    w_nextTag     = bus.m_tagid;
                    w_nextBseq    = bus.m_burst_seq;
                    w_nextTagid   = bus.m_tagid;
                    if (bus.m_cmd == CMD_WR) begin
                        w_nextState = ST_WDATA;
                    end else if (bus.m_cmd == CMD_RD) begin
                        w_nextState = ST_RDRESP;
                        if (bus.m_burst_seq == BSEQ_INCR) begin
                            w_nextResp     = RESP_DVA;
                            w_nextData     = w_memRdata;
                            w_nextRespLast = (bus.m_burst_length <= BLEN_ONE);
                        end else begin
                            w_nextResp     = RESP_ERR;
                            w_nextData     = '0;
                            w_nextRespLast = 1'b1;
                        end
                    end else begin
                        w_nextState    = ST_WRESP;
                        w_nextResp     = RESP_ERR;
                        w_nextData     = '0;
                        w_nextRespLast = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                // Beats for another tag are invisible: no write, no count.
                if (bus.m_data_valid && (bus.m_data_tagid == r_tag)) begin
                    w_memWe    = w_bseqOk;
                    w_nextBeat = r_beat + BLEN_ONE;
                    if ((r_beat == r_lastIdx) || bus.m_data_last) begin
                        w_nextState    = ST_WRESP;
                        w_nextResp     = w_bseqOk ? RESP_DVA : RESP_ERR;
                        w_nextRespLast = 1'b1;
                        w_nextData     = '0;
                        w_nextTagid    = r_tag;
                    end
                end
            end
            ST_WRESP: begin
                if (bus.m_resp_accept) begin
                    w_nextState    = ST_IDLE;
                    w_nextResp     = RESP_NULL;
                    w_nextRespLast = 1'b0;
                    w_nextData     = '0;
                end
            end
            ST_RDRESP: begin
                if (bus.m_resp_accept) begin
                    if (r_respLast) begin
                        w_nextState    = ST_IDLE;
                        w_nextResp     = RESP_NULL;
                        w_nextRespLast = 1'b0;
                        w_nextData     = '0;
                    end else begin
                        w_nextBeat     = r_beat + BLEN_ONE;
                        w_nextData     = w_memRdata;
                        w_nextRespLast = ((r_beat + BLEN_ONE) == r_lastIdx);
                    end
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_lastIdx  <= '0;
            r_beat     <= '0;
            r_tag      <= '0;
            r_bseq     <= '0;
            r_resp     <= RESP_NULL;
            r_respLast <= 1'b0;
            r_data     <= '0;
            r_tagid    <= '0;
        end else begin
            r_state    <= w_nextState;
            r_addr     <= w_nextAddr;
            r_lastIdx  <= w_nextLastIdx;
            r_beat     <= w_nextBeat;
            r_tag      <= w_nextTag;
            r_bseq     <= w_nextBseq;
            r_resp     <= w_nextResp;
            r_respLast <= w_nextRespLast;
            r_data     <= w_nextData;
            r_tagid    <= w_nextTagid;
        end
    end

    assign bus.s_cmd_accept  = (r_state == ST_IDLE);
    assign bus.s_data_accept = (r_state == ST_WDATA);
    assign bus.s_resp        = r_resp;
    assign bus.s_resp_last   = r_respLast;
    assign bus.s_data        = r_data;
    assign bus.s_tagid       = r_tagid;

endmodule

// File: tb/tb_ocp_slave_mem.sv
// Directed bench for ocp_slave_mem: a transaction-level model predicts every
// output each cycle, and literal pins anchor the model at key beats.
module tb_ocp_slave_mem;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ocp_slave_mem_if bus ();

    ocp_slave_mem dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chkEn    = 1'b0;

    logic [31:0] modelMem [32];
    logic [4:0]  curAddr;
    logic [4:0]  curTag;
    int          curLen;
    int          beatK;
    bit          curOk;

    logic        expCmdAcc;
    logic        expDataAcc;
    logic [1:0]  expResp;
    logic        expLast;
    logic [31:0] expData;
    logic [4:0]  expTag;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, the bus must match what the model says the slave is doing.
    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("cmd_accept", bus.s_cmd_accept, expCmdAcc);
            checkOutput("data_accept", bus.s_data_accept, expDataAcc);
            checkOutput("resp", bus.s_resp, expResp);
            checkOutput("resp_last", bus.s_resp_last, expLast);
            checkOutput("data", bus.s_data, expData);
            if (expResp != 2'b00) begin
                checkOutput("tagid", bus.s_tagid, expTag);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueCmd(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] len,
                            input logic [2:0] bseq, input logic [4:0] tag);
        bus.m_cmd          = cmd;
        bus.m_addr         = addr;
        bus.m_burst_length = len;
        bus.m_burst_seq    = bseq;
        bus.m_tagid        = tag;
        tick();
        bus.m_cmd = 3'b000;
        curAddr   = addr;
        curLen    = (len == 4'd0) ? 1 : int'(len);
        curTag    = tag;
        curOk     = (bseq == 3'b000);
        beatK     = 0;
        expCmdAcc = 1'b0;
        if (cmd == 3'b001) begin
            expDataAcc = 1'b1;
        end else if (cmd == 3'b010) begin
            expResp = curOk ? 2'b01 : 2'b11;
            expData = curOk ? modelMem[addr] : 32'h0;
            expLast = !curOk || (curLen == 1);
            expTag  = tag;
        end else begin
            expResp = 2'b11;
            expData = 32'h0;
            expLast = 1'b1;
            expTag  = tag;
        end
    endtask

    task automatic sendBeat(input logic [31:0] data, input logic [3:0] be,
                            input logic [4:0] tag, input logic last);
        int a;
        bus.m_data_valid  = 1'b1;
        bus.m_data        = data;
        bus.m_data_byteen = be;
        bus.m_data_tagid  = tag;
        bus.m_data_last   = last;
        tick();
        bus.m_data_valid = 1'b0;
        bus.m_data_last  = 1'b0;
        if (tag == curTag) begin
            a = (int'(curAddr) + beatK) % 32;
            if (curOk) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) modelMem[a][b*8 +: 8] = data[b*8 +: 8];
                end
            end
            beatK++;
            if ((beatK == curLen) || last) begin
                expDataAcc = 1'b0;
                expResp    = curOk ? 2'b01 : 2'b11;
                expLast    = 1'b1;
                expData    = 32'h0;
                expTag     = curTag;
            end
        end
    endtask

    task automatic acceptResp();
        bus.m_resp_accept = 1'b1;
        tick();
        bus.m_resp_accept = 1'b0;
        if (expLast) begin
            expResp   = 2'b00;
            expLast   = 1'b0;
            expData   = 32'h0;
            expCmdAcc = 1'b1;
        end else begin
            beatK++;
            expData = modelMem[(int'(curAddr) + beatK) % 32];
            expLast = (beatK == curLen - 1);
        end
    endtask

    task automatic applyStimulus();
        bus.m_addr = '0; bus.m_burst_length = '0; bus.m_burst_seq = '0; bus.m_byteen = '1;
        bus.m_cmd = '0; bus.m_data = '0; bus.m_data_byteen = '0; bus.m_data_last = 1'b0;
        bus.m_data_tagid = '0; bus.m_data_valid = 1'b0; bus.m_req_info = '0;
        bus.m_resp_accept = 1'b0; bus.m_tagid = '0;
        rst = 1'b1;
        tick();
        tick();
        expCmdAcc = 1'b1; expDataAcc = 1'b0; expResp = 2'b00; expLast = 1'b0;
        expData = 32'h0; expTag = 5'd0;
        checkOutput("rst_resp", bus.s_resp, 2'b00);
        checkOutput("rst_last", bus.s_resp_last, 1'b0);
        checkOutput("rst_data", bus.s_data, 32'h0);
        checkOutput("rst_tagid", bus.s_tagid, 5'd0);
        checkOutput("rst_data_accept", bus.s_data_accept, 1'b0);
        checkOutput("rst_cmd_accept", bus.s_cmd_accept, 1'b1);
        rst   = 1'b0;
        chkEn = 1'b1;

        // Four-beat write with a foreign-tag beat in the middle, then read back with a stall.
        issueCmd(3'b001, 5'd3, 4'd4, 3'b000, 5'd5);
        sendBeat(32'hA0, 4'hF, 5'd5, 1'b0);
        sendBeat(32'hEE, 4'hF, 5'd6, 1'b0);
        sendBeat(32'hA1, 4'hF, 5'd5, 1'b0);
        sendBeat(32'hA2, 4'hF, 5'd5, 1'b0);
        sendBeat(32'hA3, 4'hF, 5'd5, 1'b1);
        checkOutput("wr_resp_dva", bus.s_resp, 2'b01);
        checkOutput("wr_resp_tag", bus.s_tagid, 5'd5);
        checkOutput("wr_resp_last", bus.s_resp_last, 1'b1);
        acceptResp();
        issueCmd(3'b010, 5'd3, 4'd4, 3'b000, 5'd7);
        checkOutput("rd_beat0", bus.s_data, 32'hA0);
        checkOutput("rd_beat0_last", bus.s_resp_last, 1'b0);
        acceptResp();
        checkOutput("rd_beat1", bus.s_data, 32'hA1);
        repeat (3) tick();
        checkOutput("rd_hold_data", bus.s_data, 32'hA1);
        checkOutput("rd_hold_resp", bus.s_resp, 2'b01);
        checkOutput("rd_hold_tag", bus.s_tagid, 5'd7);
        acceptResp();
        checkOutput("rd_beat2", bus.s_data, 32'hA2);
        acceptResp();
        checkOutput("rd_beat3", bus.s_data, 32'hA3);
        checkOutput("rd_beat3_last", bus.s_resp_last, 1'b1);
        acceptResp();
        checkOutput("rd_done_cmd_accept", bus.s_cmd_accept, 1'b1);

        // Write and read across the top of the address space.
        issueCmd(3'b001, 5'd30, 4'd4, 3'b000, 5'd1);
        sendBeat(32'hB0, 4'hF, 5'd1, 1'b0);
        sendBeat(32'hB1, 4'hF, 5'd1, 1'b0);
        sendBeat(32'hB2, 4'hF, 5'd1, 1'b0);
        sendBeat(32'hB3, 4'hF, 5'd1, 1'b0);
        acceptResp();
        issueCmd(3'b010, 5'd30, 4'd4, 3'b000, 5'd2);
        checkOutput("wrap_w30", bus.s_data, 32'hB0);
        acceptResp();
        checkOutput("wrap_w31", bus.s_data, 32'hB1);
        acceptResp();
        checkOutput("wrap_w0", bus.s_data, 32'hB2);
        acceptResp();
        checkOutput("wrap_w1", bus.s_data, 32'hB3);
        acceptResp();

        // Partial byte enables over a cleared word; length 0 reads one beat.
        issueCmd(3'b001, 5'd10, 4'd1, 3'b000, 5'd3);
        sendBeat(32'h0, 4'hF, 5'd3, 1'b0);
        acceptResp();
        issueCmd(3'b001, 5'd10, 4'd1, 3'b000, 5'd3);
        sendBeat(32'hFFFFFFFF, 4'b0101, 5'd3, 1'b0);
        acceptResp();
        issueCmd(3'b010, 5'd10, 4'd0, 3'b000, 5'd4);
        checkOutput("byteen_data", bus.s_data, 32'h00FF00FF);
        checkOutput("len0_last", bus.s_resp_last, 1'b1);
        acceptResp();

        // Non-INCR read returns a single error beat.
        issueCmd(3'b010, 5'd3, 4'd4, 3'b001, 5'd8);
        checkOutput("bseq_rd_err", bus.s_resp, 2'b11);
        checkOutput("bseq_rd_last", bus.s_resp_last, 1'b1);
        checkOutput("bseq_rd_data", bus.s_data, 32'h0);
        acceptResp();

        // Early m_data_last leaves the second word untouched.
        issueCmd(3'b001, 5'd20, 4'd2, 3'b000, 5'd9);
        sendBeat(32'hC0, 4'hF, 5'd9, 1'b0);
        sendBeat(32'hC1, 4'hF, 5'd9, 1'b0);
        acceptResp();
        issueCmd(3'b001, 5'd20, 4'd2, 3'b000, 5'd9);
        sendBeat(32'hD0, 4'hF, 5'd9, 1'b1);
        checkOutput("early_last_dva", bus.s_resp, 2'b01);
        acceptResp();
        issueCmd(3'b010, 5'd20, 4'd2, 3'b000, 5'd10);
        checkOutput("early_w20", bus.s_data, 32'hD0);
        acceptResp();
        checkOutput("early_w21", bus.s_data, 32'hC1);
        acceptResp();

        // Unknown command and non-INCR write both answer ERR; memory unchanged.
        issueCmd(3'b011, 5'd0, 4'd1, 3'b000, 5'd11);
        checkOutput("badcmd_err", bus.s_resp, 2'b11);
        acceptResp();
        issueCmd(3'b001, 5'd3, 4'd1, 3'b010, 5'd12);
        sendBeat(32'h55, 4'hF, 5'd12, 1'b0);
        checkOutput("bseq_wr_err", bus.s_resp, 2'b11);
        acceptResp();
        issueCmd(3'b010, 5'd3, 4'd1, 3'b000, 5'd13);
        checkOutput("bseq_wr_discard", bus.s_data, 32'hA0);
        acceptResp();

        // Reset in the middle of a read burst.
        issueCmd(3'b010, 5'd30, 4'd4, 3'b000, 5'd14);
        acceptResp();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expResp = 2'b00; expLast = 1'b0; expData = 32'h0; expCmdAcc = 1'b1; expDataAcc = 1'b0;
        checkOutput("midrst_resp", bus.s_resp, 2'b00);
        checkOutput("midrst_cmd_accept", bus.s_cmd_accept, 1'b1);
        issueCmd(3'b010, 5'd31, 4'd1, 3'b000, 5'd15);
        checkOutput("midrst_mem_kept", bus.s_data, 32'hB1);
        acceptResp();
        repeat (2) tick();
        chkEn = 1'b0;
    endtask

    initial begin
        applyStimulus();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
